// File: rtl/pipe_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mem_arbiter_if
//  Description : Bus bundle for the IF/MEM-stage memory arbiter: fetch port,
//                data port, memory handshake port and pipeline stall/owner
//                outputs.
//                slave  modport : arbiter side
//                master modport : pipeline and memory side
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // Data (load/store) port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  // Memory handshake
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // Pipeline control
  logic              stall_if;
  logic              stall_mem;
  logic              owner;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ack,
    output dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, owner
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ack,
    input  dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, owner
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mem_arbiter
//  Description : Shares one single-port memory between instruction fetch (IF)
//                and load/store (DM). DM has priority; a saturating counter of
//                contested DM wins forces an IF grant once it reaches
//                STARVE_MAX. Each access runs IDLE -> BUSY -> RESP, BUSY
//                lasting until the memory raises mem_ready.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active-high
//                bus  - pipe_mem_arbiter_if.slave (fetch, data, memory,
//                       stall_if/stall_mem/owner)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pipe_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_owner;

  logic w_starved;
  logic w_grant_dm;
  logic w_grant_if;

  // DM wins every contest except when fetch has already lost STARVE_MAX in a row.
  assign w_starved  = (r_starve_cnt == c_STARVE_MAX);
  assign w_grant_dm = bus.dm_req & (~bus.if_req | ~w_starved);
  assign w_grant_if = bus.if_req & ~w_grant_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_owner      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_owner     <= 1'b1;
            r_state     <= S_BUSY;
            // Only contested DM wins count toward fetch starvation.
            if (bus.if_req && !w_starved) begin
              r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
            end
          end else if (w_grant_if) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= bus.if_addr;
            r_owner      <= 1'b0;
            r_starve_cnt <= '0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_owner) begin
              // A store returns no data; dm_rdata keeps the last load value.
              if (!r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
              end
              r_dm_ack <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_ack   <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // Ack is visible for this single cycle; requesters renew after it.
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.owner     = r_owner;
  assign bus.stall_if  = bus.if_req & ~r_if_ack;
  assign bus.stall_mem = bus.dm_req & ~r_dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_mem_arbiter
//  Description : Directed bench for pipe_mem_arbiter. A memory responder
//                answers each access after a programmable number of wait
//                states; expected acks are queued when requests are driven
//                and popped when the arbiter acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_arbiter;

  logic clk;
  logic rst;

  pipe_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   wait_states = 0;
  bit   stray_mode  = 1'b0;
  logic [31:0] last_dm = 32'h0;

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit is_dm, input string tag, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (is_dm ? bus.dm_ack : bus.if_ack) got = 1'b1;
    end
    chk({tag, "_ack_seen"}, got, 1);
  endtask

  // Memory responder: mem_ready after wait_states idle BUSY cycles.
  int wcnt = 0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (stray_mode) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (bus.mem_req) begin
        if (wcnt >= wait_states) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = model(bus.mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Ack monitor: every ack must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_ack && bus.dm_ack) begin
        chk("ack_overlap", 1, 0);
      end else if (bus.if_ack || bus.dm_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_owner", bus.dm_ack, e.owner);
          chk("ack_data", bus.dm_ack ? bus.dm_rdata : bus.if_rdata, e.data);
          chk("owner_out", bus.owner, e.owner);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_acks", {bus.if_ack, bus.dm_ack}, 0);
    chk("rst_regs", {bus.mem_addr, bus.if_rdata}, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_owner", bus.owner, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, zero-wait memory
    wait_states = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0004;
    sb.push_back('{owner: 1'b0, data: 32'h2008_0005});
    @(negedge clk);
    chk("fetch_mem_req", {bus.mem_req, bus.mem_we}, 2'b10);
    chk("fetch_mem_addr", bus.mem_addr, 32'h4);
    chk("fetch_stall_if", bus.stall_if, 1);
    wait_ack(1'b0, "fetch", cyc);
    chk("fetch_latency", cyc, 1);
    chk("fetch_stall_released", bus.stall_if, 0);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Contention: DM first, then IF
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
    sb.push_back('{owner: 1'b1, data: model(32'h10)});
    sb.push_back('{owner: 1'b0, data: model(32'h8)});
    @(negedge clk);
    chk("cont_owner", bus.owner, 1);
    chk("cont_mem_addr", bus.mem_addr, 32'h10);
    chk("cont_stalls", {bus.stall_if, bus.stall_mem}, 2'b11);
    chk("cont_cnt", dut.r_starve_cnt, 1);
    wait_ack(1'b1, "cont_dm", cyc);
    bus.dm_req = 1'b0;
    #1 chk("cont_stall_if_held", {bus.stall_if, bus.stall_mem}, 2'b10);
    wait_ack(1'b0, "cont_if", cyc);
    chk("cont_cnt_clear", dut.r_starve_cnt, 0);
    bus.if_req = 1'b0;
    last_dm = model(32'h10);
    @(negedge clk);

    // Starvation: DM and IF both held; IF wins after 4 DM grants
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    for (int i = 0; i < 4; i++) sb.push_back('{owner: 1'b1, data: model(32'h100)});
    sb.push_back('{owner: 1'b0, data: model(32'h40)});
    for (int i = 0; i < 4; i++) wait_ack(1'b1, "starve_dm", cyc);
    chk("starve_cnt_max", dut.r_starve_cnt, 4);
    wait_ack(1'b0, "starve_if", cyc);
    chk("starve_if_cycles", cyc, 3);
    chk("starve_cnt_clear", dut.r_starve_cnt, 0);
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    last_dm = model(32'h100);
    @(negedge clk);

    // Store with 3 wait states
    wait_states = 3;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'hDEAD_BEEF;
    sb.push_back('{owner: 1'b1, data: last_dm});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("store_fields", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata[29:0]},
          {2'b11, 32'h20, 30'(32'hDEAD_BEEF)});
      chk("store_no_ack", bus.dm_ack, 0);
    end
    wait_ack(1'b1, "store", cyc);
    chk("store_ack_cycles", cyc, 1);
    chk("store_dm_rdata_kept", bus.dm_rdata, last_dm);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    wait_states = 0;
    @(negedge clk);

    // Stray mem_ready in IDLE
    #2 stray_mode = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_state", dut.r_state, 0);
      chk("stray_outputs", {bus.mem_req, bus.if_ack, bus.dm_ack}, 0);
      chk("stray_rdata", {bus.if_rdata, bus.dm_rdata}, {model(32'h40), last_dm});
    end
    #2 stray_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a contested DM access
    wait_states = 20;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h30;
    bus.if_req = 1'b1; bus.if_addr = 32'h50;
    repeat (2) @(negedge clk);
    chk("midrst_busy", {bus.mem_req, bus.owner}, 2'b11);
    chk("midrst_cnt", dut.r_starve_cnt, 1);
    #2 rst = 1'b1;
    #1 chk("midrst_mem_req", bus.mem_req, 0);
    chk("midrst_acks", {bus.if_ack, bus.dm_ack}, 0);
    chk("midrst_owner_addr", {bus.owner, bus.mem_addr}, 0);
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_states = 0;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_state", dut.r_state, 0);
      chk("postrst_cnt", dut.r_starve_cnt, 0);
      chk("postrst_no_resume", bus.mem_req, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
